instr_issue_unit: RTL
=====================

Name: instr_issue_unit

Overview:
- Producer side of the processor's instruction interface.
- Holds a small program memory, loaded over a write port while idle.
- After a start pulse, it walks the program and presents each 9-bit instruction word to the processor over a valid/ready handshake.
- For immediate-type opcodes it also presents the 16-bit immediate word, then waits for the processor's done pulse before issuing the next instruction.

Parameters:
- DEPTH, 16, program memory depth in 16-bit words (power of 2).
- AW, 4, address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_we  in  1  program write strobe; honoured only in IDLE.
- ld_addr  in  AW  program write address.
- ld_data  in  16  program word.
- prog_len  in  AW+1  number of program words; sampled on start.
- start  in  1  one-cycle pulse; begins execution at address 0; ignored unless in IDLE.
- iss_valid  out  1  iss_data is valid.
- iss_ready  in  1  processor accepts the word this cycle.
- iss_data  out  16  instruction word in bits [8:0] with bits [15:9]=0, or full immediate word.
- iss_is_imm  out  1  current word is an immediate.
- done  in  1  processor finished the current instruction (one-cycle pulse).
- busy  out  1  unit is not in IDLE.
- halted  out  1  program completed normally; sticky until next start or rst.
- err  out  1  truncated immediate; sticky until next start or rst.
- pc  out  AW+1  address of the next word to fetch.
- icount  out  16  number of completed instructions.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - iss_valid, busy, halted, err and iss_is_imm are 0; pc=0, icount=0, iss_data=0.
  - Program memory contents are not reset.
  - Reset mid-operation aborts any in-flight handshake; iss_valid drops the next cycle.
- Memory: synchronous read with 1-cycle latency. ld_we outside IDLE is ignored.
- Opcode is word[8:6]. Opcodes 010 (ADD IMMEDIATE) and 111 (MOV IMMEDIATE) are two-word; all others are one-word.
- States:
  - IDLE: on start with prog_len=0, set halted=1 and stay in IDLE. On start otherwise: pc=0, icount=0, halted=0, err=0, go to FETCH_I.
  - FETCH_I: issue read at pc; pc+=1; go to ISSUE_I.
  - ISSUE_I: iss_valid=1, iss_is_imm=0, iss_data={7'b0,word[8:0]}. On iss_valid&&iss_ready: if two-word, go to FETCH_M; otherwise go to WAIT_DONE.
  - FETCH_M: if pc==prog_len, set err=1 and go to IDLE; nothing is issued. Otherwise read at pc, pc+=1, go to ISSUE_M.
  - ISSUE_M: iss_valid=1, iss_is_imm=1, iss_data=full word. On handshake, go to WAIT_DONE.
  - WAIT_DONE: on done, icount+=1 (wraps at 16'hFFFF→0). Then if pc==prog_len, set halted=1 and go to IDLE; otherwise go to FETCH_I.
- Handshake rules:
  - Once iss_valid is asserted, iss_data and iss_is_imm stay stable and iss_valid stays high until the transfer.
  - iss_valid never depends combinationally on iss_ready.
  - iss_valid is registered, so a word is never presented in a FETCH state.
- Minimum latency: start → first iss_valid = 2 cycles. done → next iss_valid = 2 cycles.
- done outside WAIT_DONE is ignored. start while busy is ignored. Simultaneous done and rst: rst wins.
- busy=1 in every state except IDLE.
- pc is AW+1 bits, so prog_len=DEPTH is legal and pc reaches DEPTH without wrap.

Test Plan:
1. Load 3 words {0x048 (ADD r1,r0), 0x0C1 (SUB), 0x000 (DISP)}, prog_len=3, start, ready=1, done 3 cycles after each accept → 3 words with iss_is_imm=0, icount=3, halted=1, busy=0.
2. Load {0x1C8 (MOV r1), 0xBEEF}, prog_len=2 → word 0x01C8 with is_imm=0, then 0xBEEF with is_imm=1; after done, halted=1, icount=1.
3. Hold iss_ready=0 for 5 cycles during ISSUE_M → iss_valid=1 and iss_data=0xBEEF stable throughout; exactly one transfer when ready rises.
4. Program {0x090 (ADD IMMEDIATE)}, prog_len=1 → instruction word issued, then err=1, halted=0, busy=0, no immediate issued.
5. Assert rst in WAIT_DONE after 2 instructions → next cycle busy=0, pc=0, icount=0; a later done pulse has no effect.
6. start pulse while busy, and ld_we while busy writing 0xFFFF → execution unaffected; memory word unchanged on a rerun after halt.

Source files
------------

// File: rtl/instr_issue_if.sv
// Instruction issue channel between the issue unit (master) and the processor (slave).
interface instr_issue_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [15:0] iss_data;
  logic        iss_is_imm;
  logic        done;

  modport master (
    output iss_valid,
    output iss_data,
    output iss_is_imm,
    input  iss_ready,
    input  done
  );

  modport slave (
    input  iss_valid,
    input  iss_data,
    input  iss_is_imm,
    output iss_ready,
    output done
  );
endinterface

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: small program memory walked after start, each word
// issued over a valid/ready channel. Two-word opcodes carry an immediate that
// is issued right behind the instruction word; the unit then waits for done.
module instr_issue_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [15:0]   ld_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  instr_issue_if.master iss,
  output logic          busy_o,
  output logic          halted_o,
  output logic          err_o,
  output logic [AW:0]   pc_o,
  output logic [15:0]   icount_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchI,
    StIssueI,
    StFetchM,
    StIssueM,
    StWaitDone
  } state_e;

  localparam logic [2:0]  OpAddi = 3'b010;
  localparam logic [2:0]  OpMovi = 3'b111;
  localparam logic [AW:0] PcOne  = (AW+1)'(1);

  state_e        state_q;
  logic          valid_q;
  logic          imm_q;
  logic [15:0]   data_q;
  logic          halted_q;
  logic          err_q;
  logic [AW:0]   pc_q;
  logic [AW:0]   len_q;
  logic [15:0]   icount_q;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   rd_word;
  logic          two_word;

  // Program memory write port; only accepted while idle, contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we_i && (state_q == StIdle)) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  // Word at the fetch pointer; it is captured by data_q at the fetch edge,
  // which makes data_q the synchronous read register of the memory.
  always_comb begin
    rd_word  = mem_q[pc_q[AW-1:0]];
    two_word = (data_q[8:6] == OpAddi) || (data_q[8:6] == OpMovi);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      imm_q    <= 1'b0;
      data_q   <= 16'h0000;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      pc_q     <= '0;
      len_q    <= '0;
      icount_q <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            err_q <= 1'b0;
            if (prog_len_i == '0) begin
              // Empty program completes immediately.
              halted_q <= 1'b1;
            end else begin
              halted_q <= 1'b0;
              pc_q     <= '0;
              icount_q <= 16'h0000;
              len_q    <= prog_len_i;
              state_q  <= StFetchI;
            end
          end
        end
        StFetchI: begin
          data_q  <= {7'b0, rd_word[8:0]};
          imm_q   <= 1'b0;
          valid_q <= 1'b1;
          pc_q    <= pc_q + PcOne;
          state_q <= StIssueI;
        end
        StIssueI: begin
          if (iss.iss_ready) begin
            valid_q <= 1'b0;
            state_q <= two_word ? StFetchM : StWaitDone;
          end
        end
        StFetchM: begin
          if (pc_q == len_q) begin
            // Immediate would lie past the end of the program.
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            data_q  <= rd_word;
            imm_q   <= 1'b1;
            valid_q <= 1'b1;
            pc_q    <= pc_q + PcOne;
            state_q <= StIssueM;
          end
        end
        StIssueM: begin
          if (iss.iss_ready) begin
            valid_q <= 1'b0;
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (iss.done) begin
            icount_q <= icount_q + 16'd1;
            if (pc_q == len_q) begin
              halted_q <= 1'b1;
              state_q  <= StIdle;
            end else begin
              state_q  <= StFetchI;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign iss.iss_valid  = valid_q;
  assign iss.iss_data   = data_q;
  assign iss.iss_is_imm = imm_q;
  assign busy_o         = (state_q != StIdle);
  assign halted_o       = halted_q;
  assign err_o          = err_q;
  assign pc_o           = pc_q;
  assign icount_o       = icount_q;

endmodule
